// File: rtl/rng_mod_reduce_if.sv
// Start/done handshake bundle between the RNG front end and rng_mod_reduce.
// The base input exists only when RNG_MOD_BASE_EN is defined.
interface rng_mod_reduce_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] value;
    logic [W-1:0] count;
`ifdef RNG_MOD_BASE_EN
    logic [W-1:0] base;
`endif
    logic         ready;
    logic         done;
    logic [W-1:0] address;
    logic         err_zero;

`ifdef RNG_MOD_BASE_EN
    modport master (output start, value, count, base,
                    input  ready, done, address, err_zero);
    modport slave  (input  start, value, count, base,
                    output ready, done, address, err_zero);
`else
    modport master (output start, value, count,
                    input  ready, done, address, err_zero);
    modport slave  (input  start, value, count,
                    output ready, done, address, err_zero);
`endif
endinterface

// File: rtl/rng_mod_reduce.sv
// Maps a raw random word to value mod count with a fixed-latency bit-serial restoring divider.
// Optional RNG_MOD_BASE_EN adds a captured base offset to the result (wraps modulo 2^W).
module rng_mod_reduce #(
    parameter int W = 16
) (
    input  logic            clock,
    input  logic            nrst,
    rng_mod_reduce_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic [W-1:0]  rem;
    logic [CW-1:0] bit_cnt;
    logic          zero_flag;
    logic          done_q;
    logic [W-1:0]  address_q;
    logic          err_zero_q;
`ifdef RNG_MOD_BASE_EN
    logic [W-1:0]  base_q;
`endif

    logic [W:0]    rem_shift;
    logic          rem_ge;
    logic [W-1:0]  rem_next;
    logic          last_bit;

    // The shifted partial remainder needs one extra bit before the compare.
    assign rem_shift = {rem, dividend[W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor});
    assign rem_next  = rem_ge ? W'(rem_shift - {1'b0, divisor}) : rem_shift[W-1:0];
    assign last_bit  = (bit_cnt == CW'(W - 1));

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.count == '0) ? FIN : DIV;
                end
            end
            DIV: begin
                if (last_bit) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            dividend   <= '0;
            divisor    <= '0;
            rem        <= '0;
            bit_cnt    <= '0;
            zero_flag  <= 1'b0;
            done_q     <= 1'b0;
            address_q  <= '0;
            err_zero_q <= 1'b0;
`ifdef RNG_MOD_BASE_EN
            base_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dividend   <= bus.value;
                        divisor    <= bus.count;
                        rem        <= '0;
                        bit_cnt    <= '0;
                        zero_flag  <= (bus.count == '0);
                        address_q  <= '0;
                        err_zero_q <= 1'b0;
`ifdef RNG_MOD_BASE_EN
                        base_q     <= bus.base;
`endif
                    end
                end
                DIV: begin
                    rem      <= rem_next;
                    dividend <= dividend << 1;
                    bit_cnt  <= bit_cnt + CW'(1);
                end
                FIN: begin
                    // Result and done are registered together so they appear in the same cycle.
                    done_q     <= 1'b1;
                    err_zero_q <= zero_flag;
`ifdef RNG_MOD_BASE_EN
                    address_q  <= zero_flag ? base_q : rem + base_q;
`else
                    address_q  <= zero_flag ? '0 : rem;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.done     = done_q;
    assign bus.address  = address_q;
    assign bus.err_zero = err_zero_q;
endmodule
